axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-master, one-slave AXI4 read-channel arbiter placed directly downstream of the instruction cache and data cache AR/R ports, feeding the single CPU AXI master interface. It serialises cache-line refill bursts: one outstanding burst at a time, round-robin grant between icache (master 0) and dcache (master 1). It buffers the accepted AR request and routes R beats back to the granted master. Write channels are outside this block.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- AW, 32, address width
- DW, 32, data width

Ports, with m0 being icache and m1 being dcache:
- clk  in  1  system clock; all logic on rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- m0_araddr, m1_araddr  in  AW  request address
- m0_arlen, m1_arlen  in  8  burst length minus one
- m0_arsize, m1_arsize  in  3  beat size
- m0_arburst, m1_arburst  in  2  burst type
- m0_arvalid, m1_arvalid  in  1  request valid; held until arready
- m0_arready, m1_arready  out  1  request accepted
- m0_rdata, m1_rdata  out  DW  returned data
- m0_rresp, m1_rresp  out  2  response
- m0_rlast, m1_rlast  out  1  last beat
- m0_rvalid, m1_rvalid  out  1  beat valid
- m0_rready, m1_rready  in  1  master accepts beat
- s_arid  out  ID_W  {ID_W-1 zeros, grant}
- s_araddr  out  AW  latched request address
- s_arlen  out  8  latched request length
- s_arsize  out  3  latched request size
- s_arburst  out  2  latched request burst type
- s_arlock  out  2  constant 0
- s_arcache  out  4  constant 0
- s_arprot  out  3  constant 0
- s_arvalid  out  1  request to slave
- s_arready  in  1  slave accepts request
- s_rid  in  ID_W  ignored except by the checker
- s_rdata  in  DW  beat data
- s_rresp  in  2  beat response
- s_rlast  in  1  last beat
- s_rvalid  in  1  beat valid
- s_rready  out  1  beat accepted
- burst_err  out  1  sticky error flag; cleared only by reset

## Operation
- State machine has three states: IDLE, ADDR, DATA.
- IDLE:
  - If exactly one m*_arvalid is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - m{g}_arready=1 combinationally in that same cycle.
  - Latch araddr/arlen/arsize/arburst into registers; set grant=g and last_grant=g.
  - Clear beat counter; go to ADDR.
- ADDR:
  - s_arvalid=1 with the latched fields.
  - On s_arready, go to DATA.
  - m*_arready=0.
- DATA:
  - m{g}_rdata/rresp/rlast/rvalid = s_r* (combinational).
  - s_rready = m{g}_rready.
  - The non-granted master sees rvalid=0 and rlast=0; its rdata/rresp are 0.
  - On each handshake (s_rvalid && s_rready), increment the beat counter.
  - Handshake with s_rlast: go to IDLE.
- burst_err is set on any of the following handshakes:
  - s_rlast=1 while count != latched arlen.
  - s_rlast=0 while count == latched arlen; the FSM remains in DATA until rlast.
  - s_rid != s_arid.
- Beat counter is 8 bits and saturates at 255.
- The arbiter issues no new AR while in ADDR or DATA; masters keep arvalid asserted and wait.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so icache wins the first tie).
  - Latched fields 0, counter 0, burst_err 0.
  - s_arvalid=0, s_rready=0.
  - All m*_arready/rvalid/rlast=0; m*_rdata/rresp=0.
- Accept in cycle t (arready pulse) → s_arvalid first high in cycle t+1.
- The minimum gap between the final rlast handshake and the next m*_arready is 0 cycles: IDLE is entered at the next edge and can grant in that same cycle.
- R path adds zero latency (pure mux). AR path adds one register stage.
- Reset asserted mid-burst:
  - Immediately return to IDLE with s_rready=0.
  - Any remaining slave beats are not forwarded; the slave is reset by the same cpu_rst.
- arvalid dropped by a master after the grant is irrelevant: the request is already latched.

## Test plan
- Single icache request: m0 araddr=0x1FC00040, arlen=15, slave arready after 2 cycles, 16 beats → m0 receives 16 beats, rlast on beat 16, s_arid=0, burst_err=0.
- Simultaneous requests right after reset: m0 and m1 both valid → m0 granted first; after m0's rlast, m1 granted with the next m1_arready; s_arid=1 for the second burst.
- Fairness: m1 requests back-to-back while m0 holds arvalid → grants alternate m0, m1, m0, m1…; neither master waits more than one full burst.
- Backpressure: m1 rready toggles 1,0,1,0 during an 8-beat burst → s_rready mirrors it; beats are not duplicated or lost; m0_rvalid stays 0 throughout.
- Protocol errors:
  - arlen=3, slave asserts rlast on beat 2 → burst_err=1, FSM returns to IDLE.
  - Separate run: wrong s_rid → burst_err=1.
- Reset mid-DATA at beat 5 of 16 → all outputs return to reset values asynchronously; the next request is granted normally once reset is released.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: round-robin grant, one outstanding burst,
// AR request registered once, R beats muxed straight back to the owner.
module axi_rd_arbiter #(
  parameter int ID_W = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            cpu_rst,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  input  logic [1:0]      m0_arburst,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rlast,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  input  logic [1:0]      m1_arburst,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rlast,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [ID_W-1:0] s_arid,
  output logic [AW-1:0]   s_araddr,
  output logic [7:0]      s_arlen,
  output logic [2:0]      s_arsize,
  output logic [1:0]      s_arburst,
  output logic [1:0]      s_arlock,
  output logic [3:0]      s_arcache,
  output logic [2:0]      s_arprot,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [ID_W-1:0] s_rid,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rlast,
  input  logic            s_rvalid,
  output logic            s_rready,
  output logic            burst_err,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid is never withdrawn before ready, and ready may depend on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            req_g;
  logic            r_hs;
  logic [ID_W-1:0] arid;

  assign arid      = ID_W'(grant_q);
  assign s_arid    = arid;
  assign s_araddr  = addr_q;
  assign s_arlen   = len_q;
  assign s_arsize  = size_q;
  assign s_arburst = burst_q;
  assign s_arlock  = '0;
  assign s_arcache = '0;
  assign s_arprot  = '0;
  assign burst_err = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rdata     = '0;
    m0_rresp     = '0;
    m0_rlast     = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rdata     = '0;
    m1_rresp     = '0;
    m1_rlast     = 1'b0;
    m1_rvalid    = 1'b0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    r_hs         = 1'b0;
    // On a tie the master that did not win last time goes first.
    req_g        = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;

    case (state_q)
      IDLE: begin
        // Reset gating keeps arready low while cpu_rst is held.
        if (!cpu_rst && (m0_arvalid || m1_arvalid)) begin
          m0_arready   = ~req_g;
          m1_arready   = req_g;
          grant_d      = req_g;
          last_grant_d = req_g;
          addr_d       = req_g ? m1_araddr  : m0_araddr;
          len_d        = req_g ? m1_arlen   : m0_arlen;
          size_d       = req_g ? m1_arsize  : m0_arsize;
          burst_d      = req_g ? m1_arburst : m0_arburst;
          cnt_d        = '0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        if (grant_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        r_hs = s_rvalid && s_rready;
        if (r_hs) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // cnt_q counts beats already taken, so the last beat sees cnt_q == arlen.
          if ((s_rlast && (cnt_q != len_q)) || (!s_rlast && (cnt_q == len_q)) ||
              (s_rid != arid))
            err_d = 1'b1;
          if (s_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: round-robin grant model, beat scoreboard,
// sticky error model and asynchronous reset checks.
module tb_axi_rd_arbiter;
  localparam int ID_W = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int W    = DW + 3;

  logic            clk = 1'b0;
  logic            cpu_rst = 1'b1;
  logic [AW-1:0]   m0_araddr = '0, m1_araddr = '0;
  logic [7:0]      m0_arlen = '0, m1_arlen = '0;
  logic [2:0]      m0_arsize = '0, m1_arsize = '0;
  logic [1:0]      m0_arburst = '0, m1_arburst = '0;
  logic            m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic            m0_arready, m1_arready;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic [1:0]      m0_rresp, m1_rresp;
  logic            m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic            m0_rready = 1'b0, m1_rready = 1'b0;
  logic [ID_W-1:0] s_arid;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize, s_arprot;
  logic [1:0]      s_arburst, s_arlock;
  logic [3:0]      s_arcache;
  logic            s_arvalid;
  logic            s_arready = 1'b0;
  logic [ID_W-1:0] s_rid = '0;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      s_rresp = '0;
  logic            s_rlast = 1'b0, s_rvalid = 1'b0;
  logic            s_rready;
  logic            burst_err;
  logic [1:0]      dbg_state;

  axi_rd_arbiter #(.ID_W(ID_W), .AW(AW), .DW(DW)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
    .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .burst_err(burst_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0]  exp_q[$];
  int            exp_master = 0;
  int            model_last = 1;
  bit            model_err  = 1'b0;
  logic [AW-1:0] req_addr[2];
  logic [7:0]    req_len[2];
  logic [2:0]    req_size[2];
  logic [1:0]    req_burst[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every beat a master accepts must be the next slave beat
  always @(negedge clk) begin
    if (!cpu_rst) begin
      if (m0_rvalid && m0_rready) begin
        check("m0_beat_owner", 0, exp_master);
        check("m0_beat_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("m0_beat", {m0_rlast, m0_rresp, m0_rdata}, exp_q.pop_front());
      end
      if (m1_rvalid && m1_rready) begin
        check("m1_beat_owner", 1, exp_master);
        check("m1_beat_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("m1_beat", {m1_rlast, m1_rresp, m1_rdata}, exp_q.pop_front());
      end
    end
  end

  task automatic reset_outputs_check(input string tag);
    check({tag, "_arready"}, {m0_arready, m1_arready}, 0);
    check({tag, "_rvalid"}, {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 0);
    check({tag, "_rresp"}, {m0_rresp, m1_rresp}, 0);
    check({tag, "_s_ar_r"}, {s_arvalid, s_rready}, 0);
    check({tag, "_burst_err"}, burst_err, 0);
    check({tag, "_s_arfields"}, {s_araddr, s_arlen, s_arsize, s_arburst}, 0);
  endtask

  // Driver tasks
  task automatic clear_inputs();
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rid = '0;
  endtask

  task automatic release_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_check("rst");
    cpu_rst = 0;
    model_last = 1;
    model_err = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_rst = 1;
    release_reset();
  endtask

  task automatic post(input int m, input logic [AW-1:0] a, input logic [7:0] l);
    req_addr[m]  = a;
    req_len[m]   = l;
    req_size[m]  = 3'($urandom_range(0, 7));
    req_burst[m] = 2'($urandom_range(0, 2));
    if (m == 0) begin
      m0_araddr = a; m0_arlen = l; m0_arsize = req_size[0]; m0_arburst = req_burst[0];
      m0_arvalid = 1;
    end else begin
      m1_araddr = a; m1_arlen = l; m1_arsize = req_size[1]; m1_arburst = req_burst[1];
      m1_arvalid = 1;
    end
  endtask

  task automatic set_rready(input int g, input logic rr, input logic oth);
    if (g == 0) begin m0_rready = rr; m1_rready = oth; end
    else begin m1_rready = rr; m0_rready = oth; end
  endtask

  // rr_mode: 0 random rready with random rvalid gaps, 1 toggling 1,0,1,0, 2 always ready.
  // rlast_idx < 0 puts rlast on beat arlen; abort_beat >= 0 resets before that beat.
  task automatic serve_burst(input int ar_dly, input int rlast_idx, input bit bad_id,
                             input int rr_mode, input int abort_beat, input bit expect_now);
    int w, g, nb, cyc;
    bit p0, p1, hs, tog;
    logic rr;
    logic [7:0] len, cnt;
    for (w = 0; w < 50; w++) begin
      @(negedge clk);
      if (m0_arready || m1_arready) break;
      @(posedge clk);
      #1;
    end
    check("ar_grant_seen", w < 50, 1);
    if (expect_now) check("ar_grant_gap", w, 0);
    p0 = m0_arvalid;
    p1 = m1_arvalid;
    g = (p0 && p1) ? 1 - model_last : (p1 ? 1 : 0);
    check("arready_m0", m0_arready, g == 0);
    check("arready_m1", m1_arready, g == 1);
    len = req_len[g];
    model_last = g;
    exp_master = g;
    @(posedge clk);
    #1;
    if (g == 0) m0_arvalid = 0; else m1_arvalid = 0;
    for (int d = 0; d < ar_dly; d++) begin
      @(negedge clk);
      check("s_arvalid_wait", s_arvalid, 1);
      check("arready_in_addr", m0_arready | m1_arready, 0);
      @(posedge clk);
      #1;
    end
    s_arready = 1;
    @(negedge clk);
    check("s_arvalid", s_arvalid, 1);
    check("s_araddr", s_araddr, req_addr[g]);
    check("s_arlen", s_arlen, len);
    check("s_arsize_burst", {s_arsize, s_arburst}, {req_size[g], req_burst[g]});
    check("s_arid", s_arid, g);
    check("s_ar_consts", {s_arlock, s_arcache, s_arprot}, 0);
    @(posedge clk);
    #1;
    s_arready = 0;

    nb = (rlast_idx < 0) ? int'(len) + 1 : rlast_idx + 1;
    cnt = 0;
    tog = 1;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_beat) begin
        // Slave still presenting a beat when reset arrives mid-cycle
        s_rvalid = 1; s_rlast = 0; s_rid = ID_W'(g); s_rdata = $urandom;
        set_rready(g, 1, 1);
        m1_arvalid = 1;
        #2;
        cpu_rst = 1;
        #1;
        reset_outputs_check("abort");
        return;
      end
      if (rr_mode == 0) begin
        repeat ($urandom_range(0, 1)) begin
          s_rvalid = 0;
          rr = 1'($urandom_range(0, 1));
          set_rready(g, rr, 1'($urandom_range(0, 1)));
          @(negedge clk);
          check("rvalid_gap", g ? m1_rvalid : m0_rvalid, 0);
          check("s_rready_gap", s_rready, rr);
          @(posedge clk);
          #1;
        end
      end
      s_rvalid = 1;
      s_rdata  = $urandom;
      s_rresp  = 2'($urandom_range(0, 3));
      s_rlast  = (i == nb - 1);
      s_rid    = bad_id ? ID_W'(g + 2) : ID_W'(g);
      exp_q.push_back({s_rlast, s_rresp, s_rdata});
      cyc = 0;
      do begin
        if (rr_mode == 0) rr = 1'($urandom_range(0, 1));
        else if (rr_mode == 1) begin rr = tog; tog = ~tog; end
        else rr = 1;
        set_rready(g, rr, 1'($urandom_range(0, 1)));
        @(negedge clk);
        check("s_rready_fwd", s_rready, rr);
        check("rvalid_fwd", g ? m1_rvalid : m0_rvalid, 1);
        check("rlast_fwd", g ? m1_rlast : m0_rlast, s_rlast);
        check("other_r", {(g ? m0_rvalid : m1_rvalid), (g ? m0_rlast : m1_rlast),
                          (g ? m0_rresp : m1_rresp), (g ? m0_rdata : m1_rdata)}, 0);
        hs = rr;
        @(posedge clk);
        #1;
        cyc++;
      end while (!hs && cyc < 64);
      check("beat_hs", hs, 1);
      if ((s_rlast && cnt != len) || (!s_rlast && cnt == len) || bad_id) model_err = 1;
      if (cnt != 8'hFF) cnt++;
    end
    s_rvalid = 0;
    s_rlast  = 0;
    set_rready(g, 0, 0);
    check("burst_err", burst_err, model_err);
    check("beats_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int m;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Single icache refill, 16 beats, slave arready after 2 cycles
    post(0, 32'h1FC0_0040, 8'd15);
    serve_burst(2, -1, 0, 2, -1, 0);

    // Simultaneous requests right after reset: m0 first, then m1 at once
    do_reset();
    post(0, 32'h0000_1000, 8'd3);
    post(1, 32'h8000_2000, 8'd3);
    serve_burst(1, -1, 0, 0, -1, 1);
    serve_burst(0, -1, 0, 0, -1, 1);

    // Fairness: both keep requesting, grants must alternate
    post(0, $urandom, 8'($urandom_range(0, 7)));
    post(1, $urandom, 8'($urandom_range(0, 7)));
    for (int k = 0; k < 6; k++) begin
      serve_burst($urandom_range(0, 3), -1, 0, 0, -1, 1);
      post(model_last, $urandom, 8'($urandom_range(0, 7)));
    end
    serve_burst(0, -1, 0, 0, -1, 1);
    serve_burst(0, -1, 0, 0, -1, 1);

    // Backpressure on m1: rready 1,0,1,0 over an 8-beat burst
    post(1, 32'hDEAD_0000, 8'd7);
    serve_burst(1, -1, 0, 1, -1, 1);

    // Random traffic
    for (int k = 0; k < 12; k++) begin
      m = $urandom_range(1, 3);
      if (m[0] && !m0_arvalid) post(0, $urandom, 8'($urandom_range(0, 7)));
      if (m[1] && !m1_arvalid) post(1, $urandom, 8'($urandom_range(0, 7)));
      serve_burst($urandom_range(0, 3), -1, 0, 0, -1, 1);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Early rlast: arlen=3, rlast on beat 2; error sticks across the next burst
    do_reset();
    post(0, 32'h0000_4000, 8'd3);
    serve_burst(0, 1, 0, 2, -1, 1);
    post(1, 32'h0000_5000, 8'd2);
    serve_burst(0, -1, 0, 2, -1, 1);

    // Missing rlast on the final counted beat
    do_reset();
    post(1, 32'h0000_6000, 8'd1);
    serve_burst(0, 3, 0, 0, -1, 1);

    // Wrong response ID
    do_reset();
    post(1, 32'h0000_7000, 8'd2);
    serve_burst(1, -1, 1, 2, -1, 1);

    // Reset in the middle of a 16-beat burst, then a normal tie request
    do_reset();
    post(0, 32'h1FC0_0080, 8'd15);
    serve_burst(0, -1, 0, 2, 5, 1);
    release_reset();
    post(0, 32'h0000_8000, 8'd2);
    post(1, 32'h0000_9000, 8'd2);
    serve_burst(0, -1, 0, 0, -1, 1);
    serve_burst(0, -1, 0, 0, -1, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
